// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer
//  Purpose  : Sequences one multiply-accumulate command. It clears the Mac,
//             streams N window/filter operand pairs from two synchronous-read
//             buffers into it, captures the accumulated result and offers it
//             on a valid/ready output port.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_taps,
    output logic              busy,
    output logic              err_zero,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] win_data,
    input  logic [DATA_W-1:0] filt_data,
    output logic [DATA_W-1:0] mac_window,
    output logic [DATA_W-1:0] mac_filter,
    output logic              mac_reg_en,
    output logic              mac_clean_reg,
    input  logic [RES_W-1:0]  mac_result,
    output logic [RES_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_FETCH   = 3'd2;
    localparam logic [2:0] c_DRAIN   = 3'd3;
    localparam logic [2:0] c_CAPTURE = 3'd4;
    localparam logic [2:0] c_OUTPUT  = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_last_addr;   // N-1, the final address of the command
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_valid;    // buffer data is valid this cycle
    logic [DATA_W-1:0] r_mac_window;
    logic [DATA_W-1:0] r_mac_filter;
    logic              r_mac_reg_en;
    logic [RES_W-1:0]  r_out_data;
    logic              r_err_zero;
    logic              w_accept;
    logic              w_zero_cmd;
    logic              w_rd_en;

    assign w_accept   = (r_state == c_IDLE) && start && (num_taps != '0);
    assign w_zero_cmd = (r_state == c_IDLE) && start && (num_taps == '0);
    assign w_rd_en    = (r_state == c_CLEAR) || (r_state == c_FETCH);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; DRAIN ends once the last accumulate is being applied
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_accept) w_next_state = c_CLEAR;
            c_CLEAR:   w_next_state = (r_last_addr != '0) ? c_FETCH : c_DRAIN;
            c_FETCH:   if (r_rd_addr == r_last_addr) w_next_state = c_DRAIN;
            c_DRAIN:   if (!r_rd_valid && r_mac_reg_en) w_next_state = c_CAPTURE;
            c_CAPTURE: w_next_state = c_OUTPUT;
            c_OUTPUT:  if (out_ready) w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // Command capture, read address counter and zero-tap error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_addr <= '0;
            r_rd_addr   <= '0;
            r_err_zero  <= 1'b0;
        end else begin
            r_err_zero <= w_zero_cmd;
            if (w_accept) begin
                r_last_addr <= num_taps[ADDR_W-1:0] - 1'b1;
            end
            if (w_rd_en && (w_next_state == c_FETCH)) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end else if ((r_state == c_IDLE) || (w_next_state == c_IDLE)) begin
                r_rd_addr <= '0;
            end
        end
    end

    // Operand pipeline: buffer data arrives one cycle after the read and is
    // registered toward the Mac together with its accumulate enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid   <= 1'b0;
            r_mac_window <= '0;
            r_mac_filter <= '0;
            r_mac_reg_en <= 1'b0;
        end else begin
            r_rd_valid   <= w_rd_en;
            r_mac_reg_en <= r_rd_valid;
            if (r_rd_valid) begin
                r_mac_window <= win_data;
                r_mac_filter <= filt_data;
            end
        end
    end

    // Result capture after the final accumulate has settled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (r_state == c_CAPTURE) begin
            r_out_data <= mac_result;
        end
    end

    assign busy          = (r_state != c_IDLE);
    assign err_zero      = r_err_zero;
    assign rd_en         = w_rd_en;
    assign rd_addr       = r_rd_addr;
    assign mac_window    = r_mac_window;
    assign mac_filter    = r_mac_filter;
    assign mac_reg_en    = r_mac_reg_en;
    assign mac_clean_reg = (r_state == c_CLEAR);
    assign out_data      = r_out_data;
    assign out_valid     = (r_state == c_OUTPUT);

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_sequencer
//  Purpose  : Directed self-checking bench for mac_sequencer with a simple
//             Mac model and two synchronous-read operand buffers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_taps;
    logic        busy;
    logic        err_zero;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [7:0]  win_data;
    logic [7:0]  filt_data;
    logic [7:0]  mac_window;
    logic [7:0]  mac_filter;
    logic        mac_reg_en;
    logic        mac_clean_reg;
    logic [11:0] mac_result;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic [7:0]  win_mem  [16];
    logic [7:0]  filt_mem [16];
    logic [15:0] w_prod;

    int total = 0;
    int bad   = 0;

    mac_sequencer #(.ADDR_W(4), .DATA_W(8), .RES_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_taps     (num_taps),
        .busy         (busy),
        .err_zero     (err_zero),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .win_data     (win_data),
        .filt_data    (filt_data),
        .mac_window   (mac_window),
        .mac_filter   (mac_filter),
        .mac_reg_en   (mac_reg_en),
        .mac_clean_reg(mac_clean_reg),
        .mac_result   (mac_result),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read operand buffers
    always @(posedge clk) begin
        if (rd_en) begin
            win_data  <= win_mem[rd_addr];
            filt_data <= filt_mem[rd_addr];
        end
    end

    // Mac model: accumulates the upper product byte, cleared by clean_reg
    assign w_prod = {8'b0, mac_window} * {8'b0, mac_filter};
    always @(posedge clk or posedge rst) begin
        if (rst)                mac_result <= '0;
        else if (mac_clean_reg) mac_result <= '0;
        else if (mac_reg_en)    mac_result <= mac_result + {4'b0, w_prod[15:8]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_taps = '0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin win_mem[i] = 8'h00; filt_mem[i] = 8'h00; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_rd_en",     32'(rd_en),         32'd0);
        chk("rst_rd_addr",   32'(rd_addr),       32'd0);
        chk("rst_reg_en",    32'(mac_reg_en),    32'd0);
        chk("rst_clean",     32'(mac_clean_reg), 32'd0);
        chk("rst_out_valid", 32'(out_valid),     32'd0);
        chk("rst_out_data",  32'(out_data),      32'd0);
        chk("rst_err_zero",  32'(err_zero),      32'd0);
        rst = 1'b0;
        tick();

        // Single tap
        win_mem[0] = 8'hFF; filt_mem[0] = 8'hFF; out_ready = 1'b1;
        start = 1'b1; num_taps = 5'd1;
        tick(); start = 1'b0;                                  // cycle 1
        chk("n1_c1_clean",  32'(mac_clean_reg), 32'd1);
        chk("n1_c1_rd_en",  32'(rd_en),         32'd1);
        chk("n1_c1_addr",   32'(rd_addr),       32'd0);
        chk("n1_c1_busy",   32'(busy),          32'd1);
        chk("n1_c1_reg_en", 32'(mac_reg_en),    32'd0);
        tick();                                                // cycle 2
        chk("n1_c2_reg_en", 32'(mac_reg_en),    32'd0);
        chk("n1_c2_rd_en",  32'(rd_en),         32'd0);
        chk("n1_c2_clean",  32'(mac_clean_reg), 32'd0);
        tick();                                                // cycle 3
        chk("n1_c3_reg_en", 32'(mac_reg_en),    32'd1);
        chk("n1_c3_win",    32'(mac_window),    32'hFF);
        chk("n1_c3_filt",   32'(mac_filter),    32'hFF);
        tick();                                                // cycle 4
        chk("n1_c4_reg_en", 32'(mac_reg_en),    32'd0);
        chk("n1_c4_valid",  32'(out_valid),     32'd0);
        tick();                                                // cycle 5
        chk("n1_c5_valid",  32'(out_valid),     32'd1);
        chk("n1_c5_data",   32'(out_data),      32'h0FE);
        tick();                                                // cycle 6
        chk("n1_c6_valid",  32'(out_valid),     32'd0);
        chk("n1_c6_busy",   32'(busy),          32'd0);

        // Full depth
        for (int i = 0; i < 16; i++) begin win_mem[i] = 8'hFF; filt_mem[i] = 8'hFF; end
        start = 1'b1; num_taps = 5'd16;
        tick(); start = 1'b0;                                  // cycle 1
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("n16_addr_c%0d", k), 32'(rd_addr), 32'(k - 1));
            chk($sformatf("n16_rd_en_c%0d", k), 32'(rd_en), 32'd1);
            tick();
        end                                                    // cycle 17
        chk("n16_c17_rd_en", 32'(rd_en),     32'd0);
        tick(); tick();                                        // cycle 19
        chk("n16_c19_valid", 32'(out_valid), 32'd0);
        tick();                                                // cycle 20
        chk("n16_c20_valid", 32'(out_valid), 32'd1);
        chk("n16_c20_data",  32'(out_data),  32'hFE0);
        tick();
        chk("n16_c21_valid", 32'(out_valid), 32'd0);

        // Back-to-back with accumulator clear
        win_mem[0] = 8'h10; filt_mem[0] = 8'h20;               // 0x02
        win_mem[1] = 8'h40; filt_mem[1] = 8'h40;               // 0x10
        start = 1'b1; num_taps = 5'd2;
        tick(); start = 1'b0;                                  // cycle 1
        repeat (5) tick();                                     // cycle 6
        chk("b2b_a_valid", 32'(out_valid), 32'd1);
        chk("b2b_a_data",  32'(out_data),  32'h012);
        win_mem[0] = 8'hFF; filt_mem[0] = 8'h80;               // 0x7F
        win_mem[1] = 8'h02; filt_mem[1] = 8'h80;               // 0x01
        tick();                                                // cycle 7, IDLE
        chk("b2b_idle_busy",  32'(busy),      32'd0);
        chk("b2b_idle_valid", 32'(out_valid), 32'd0);
        start = 1'b1; num_taps = 5'd2;
        tick(); start = 1'b0;                                  // second cycle 1
        chk("b2b_b_clean", 32'(mac_clean_reg), 32'd1);
        repeat (5) tick();                                     // second cycle 6
        chk("b2b_b_valid", 32'(out_valid), 32'd1);
        chk("b2b_b_data",  32'(out_data),  32'h080);
        tick();

        // Zero taps
        start = 1'b1; num_taps = 5'd0;
        tick(); start = 1'b0;                                  // cycle 1
        chk("zero_err",   32'(err_zero),      32'd1);
        chk("zero_busy",  32'(busy),          32'd0);
        chk("zero_rd_en", 32'(rd_en),         32'd0);
        chk("zero_clean", 32'(mac_clean_reg), 32'd0);
        tick();                                                // cycle 2
        chk("zero_err_c2",  32'(err_zero), 32'd0);
        chk("zero_busy_c2", 32'(busy),     32'd0);

        // Backpressure
        out_ready = 1'b0;
        win_mem[0] = 8'hFF; filt_mem[0] = 8'h80;               // 0x7F
        win_mem[1] = 8'hFF; filt_mem[1] = 8'h40;               // 0x3F
        win_mem[2] = 8'hFF; filt_mem[2] = 8'h20;               // 0x1F
        win_mem[3] = 8'hFF; filt_mem[3] = 8'h10;               // 0x0F -> 0xEC
        start = 1'b1; num_taps = 5'd4;
        tick(); start = 1'b0;                                  // cycle 1
        tick();                                                // cycle 2
        start = 1'b1; num_taps = 5'd3;
        tick(); start = 1'b0;                                  // cycle 3
        chk("bp_c3_busy", 32'(busy),    32'd1);
        chk("bp_c3_addr", 32'(rd_addr), 32'd2);
        repeat (5) tick();                                     // cycle 8
        for (int c = 8; c <= 17; c++) begin
            chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_data_c%0d", c),  32'(out_data),  32'h0EC);
            chk($sformatf("bp_busy_c%0d", c),  32'(busy),      32'd1);
            start = (c == 10);
            num_taps = 5'd3;
            tick();
        end                                                    // cycle 18
        start = 1'b0;
        out_ready = 1'b1;
        chk("bp_c18_valid", 32'(out_valid), 32'd1);
        chk("bp_c18_data",  32'(out_data),  32'h0EC);
        tick();                                                // cycle 19
        chk("bp_c19_valid", 32'(out_valid), 32'd0);
        chk("bp_c19_busy",  32'(busy),      32'd0);
        out_ready = 1'b0;
        tick();

        // Reset mid-FETCH
        for (int i = 0; i < 8; i++) begin win_mem[i] = 8'h11 * 8'(i + 1); filt_mem[i] = 8'h33; end
        out_ready = 1'b1;
        start = 1'b1; num_taps = 5'd8;
        tick(); start = 1'b0;                                  // cycle 1
        repeat (3) tick();                                     // cycle 4
        chk("mr_c4_reg_en", 32'(mac_reg_en), 32'd1);
        chk("mr_c4_addr",   32'(rd_addr),    32'd3);
        rst = 1'b1;
        #1;
        chk("mr_busy",   32'(busy),          32'd0);
        chk("mr_rd_en",  32'(rd_en),         32'd0);
        chk("mr_addr",   32'(rd_addr),       32'd0);
        chk("mr_reg_en", 32'(mac_reg_en),    32'd0);
        chk("mr_clean",  32'(mac_clean_reg), 32'd0);
        chk("mr_win",    32'(mac_window),    32'd0);
        chk("mr_filt",   32'(mac_filter),    32'd0);
        chk("mr_valid",  32'(out_valid),     32'd0);
        chk("mr_data",   32'(out_data),      32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("mr_post_valid_%0d", c), 32'(out_valid), 32'd0);
            chk($sformatf("mr_post_busy_%0d", c),  32'(busy),      32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
